imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 143 ++++++++++++++
 tb/tb_imem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: loadable word memory answering core fetches through an
// IDLE/WAIT/RESP handshake, with the response presented from a registered output stage.
module imem_responder #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           imem_read_en,
   input  logic [31:0]                    imem_addr,
   output logic [31:0]                    imem_rdata,
   output logic                           imem_valid,
   output logic                           imem_busy,
   output logic                           imem_error,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [31:0]                    load_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   logic [31:0] mem [DEPTH_WORDS];

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] cap_data_q, cap_data_d;
   logic        cap_err_q, cap_err_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        error_q, error_d;
   logic [31:0] rdata_q, rdata_d;

   logic             accept;
   logic [31:0]      fetch_addr;
   logic             fetch_err;
   logic [IDX_W-1:0] fetch_idx;

   // With zero wait states the fetch is captured on the accepting edge, so the
   // address must come straight from the port rather than from addr_q.
   always_comb begin
      accept     = imem_read_en && ((state_q == IDLE) || (state_q == RESP));
      fetch_addr = accept ? imem_addr : addr_q;
      fetch_err  = (fetch_addr[1:0] != 2'b00) ||
                   ({2'b00, fetch_addr[31:2]} >= 32'(DEPTH_WORDS));
      fetch_idx  = fetch_addr[IDX_W+1:2];
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      cap_data_d = cap_data_q;
      cap_err_d  = cap_err_q;

      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               addr_d = imem_addr;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // Entering RESP always means a fresh capture; the memory read sees the
      // pre-write contents if a load hits the same word on this edge.
      if (state_d == RESP) begin
         cap_err_d  = fetch_err;
         cap_data_d = fetch_err ? NOP_WORD : mem[fetch_idx];
      end
   end

   always_comb begin
      busy_d  = (state_d == WAIT);
      valid_d = (state_q == RESP);
      error_d = (state_q == RESP) && cap_err_q;
      rdata_d = (state_q == RESP) ? cap_data_q : rdata_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 32'd0;
         cap_data_q <= 32'd0;
         cap_err_q  <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         cap_data_q <= cap_data_d;
         cap_err_q  <= cap_err_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
         rdata_q    <= rdata_d;
      end
   end

   // NOTE: the memory array has no reset so a preloaded program survives reset and maps to RAM.
   always_ff @(posedge clk) begin
      if (load_en && (32'(load_addr) < 32'(DEPTH_WORDS))) begin
         mem[load_addr] <= load_data;
      end
   end

   assign imem_valid = valid_q;
   assign imem_busy  = busy_q;
   assign imem_error = error_q;
   assign imem_rdata = rdata_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (0, 1 and 3 wait states) share
// stimulus; each scenario task checks its own instance against hand-computed values.
module tb_imem_responder;

   logic        clk;
   logic        reset;
   logic        read_en;
   logic [31:0] addr;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;

   logic [31:0] rdata0, rdata1, rdata3;
   logic        valid0, valid1, valid3;
   logic        busy0, busy1, busy3;
   logic        error0, error1, error3;

   int checks;
   int errors;

   imem_responder #(.WAIT_STATES(0)) dut_w0 (
      .clk(clk), .reset(reset), .imem_read_en(read_en), .imem_addr(addr),
      .imem_rdata(rdata0), .imem_valid(valid0), .imem_busy(busy0), .imem_error(error0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   imem_responder #(.WAIT_STATES(1)) dut_w1 (
      .clk(clk), .reset(reset), .imem_read_en(read_en), .imem_addr(addr),
      .imem_rdata(rdata1), .imem_valid(valid1), .imem_busy(busy1), .imem_error(error1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   imem_responder #(.WAIT_STATES(3)) dut_w3 (
      .clk(clk), .reset(reset), .imem_read_en(read_en), .imem_addr(addr),
      .imem_rdata(rdata3), .imem_valid(valid3), .imem_busy(busy3), .imem_error(error3),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [7:0] idx, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = idx;
      load_data = d;
      step();
      load_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", valid1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
      checks++; if (error1 !== 1'b0) begin errors++; $display("FAIL reset_error1: got %b want 0", error1); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h want 00000000", rdata1); end
      checks++; if (valid0 !== 1'b0 || busy3 !== 1'b0) begin
         errors++; $display("FAIL reset_others: got valid0=%b busy3=%b want 0 0", valid0, busy3);
      end
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_single_fetch();
      load_word(8'd0, 32'h0050_0093);
      read_en = 1'b1; addr = 32'h0;
      step();
      read_en = 1'b0;
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_n: got %b want 1", busy1); end
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL single_valid_n: got %b want 0", valid1); end
      step();
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_n1: got %b want 0", busy1); end
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL single_valid_n1: got %b want 0", valid1); end
      step();
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL single_valid_n2: got %b want 1", valid1); end
      checks++; if (rdata1 !== 32'h0050_0093) begin errors++; $display("FAIL single_rdata: got %h want 00500093", rdata1); end
      checks++; if (error1 !== 1'b0) begin errors++; $display("FAIL single_error: got %b want 0", error1); end
      step();
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL single_valid_n3: got %b want 0", valid1); end
      checks++; if (rdata1 !== 32'h0050_0093) begin errors++; $display("FAIL single_rdata_hold: got %h want 00500093", rdata1); end
   endtask

   task automatic test_errors();
      logic [31:0] bad [2];
      bad[0] = 32'h0000_0002;
      bad[1] = 32'h0000_0400;
      for (int i = 0; i < 2; i++) begin
         read_en = 1'b1; addr = bad[i];
         step();
         read_en = 1'b0;
         step();
         checks++; if (valid1 !== 1'b0 || error1 !== 1'b0) begin
            errors++; $display("FAIL err_early[%0d]: got valid=%b error=%b want 0 0", i, valid1, error1);
         end
         step();
         checks++; if (valid1 !== 1'b1 || error1 !== 1'b1) begin
            errors++; $display("FAIL err_resp[%0d]: got valid=%b error=%b want 1 1", i, valid1, error1);
         end
         checks++; if (rdata1 !== 32'h0000_0013) begin
            errors++; $display("FAIL err_rdata[%0d]: got %h want 00000013", i, rdata1);
         end
         step();
         checks++; if (error1 !== 1'b0) begin errors++; $display("FAIL err_clear[%0d]: got %b want 0", i, error1); end
      end
   endtask

   task automatic test_wait_drop();
      int pulses;
      int at;
      logic [31:0] seen;
      pulses = 0; at = -1; seen = 32'h0;
      read_en = 1'b1; addr = 32'h0;
      step();
      checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL drop_busy_n: got %b want 1", busy3); end
      addr = 32'h4;
      step();
      step();
      checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL drop_busy_n2: got %b want 1", busy3); end
      read_en = 1'b0;
      for (int i = 3; i <= 10; i++) begin
         step();
         if (valid3 === 1'b1) begin
            pulses++;
            at = i;
            seen = rdata3;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
      checks++; if (at !== 4) begin errors++; $display("FAIL drop_latency: got %0d want 4", at); end
      checks++; if (seen !== 32'h0050_0093) begin errors++; $display("FAIL drop_rdata: got %h want 00500093", seen); end
   endtask

   task automatic test_reset_mid_wait();
      int pulses;
      int at;
      logic [31:0] seen;
      read_en = 1'b1; addr = 32'h0;
      step();
      read_en = 1'b0;
      checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", busy3); end
      #2 reset = 1'b0;
      #1;
      checks++; if (busy3 !== 1'b0 || valid3 !== 1'b0 || error3 !== 1'b0) begin
         errors++; $display("FAIL rst_async_flags: got busy=%b valid=%b error=%b want 0 0 0", busy3, valid3, error3);
      end
      checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rst_async_rdata: got %h want 00000000", rdata3); end
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (valid3 === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_valid: got %0d pulses want 0", pulses); end
      read_en = 1'b1; addr = 32'h0;
      step();
      read_en = 1'b0;
      at = -1; seen = 32'h0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (valid3 === 1'b1) begin
            at = i;
            seen = rdata3;
         end
      end
      checks++; if (at !== 4) begin errors++; $display("FAIL rst_refetch_latency: got %0d want 4", at); end
      checks++; if (seen !== 32'h0050_0093) begin errors++; $display("FAIL rst_mem_kept: got %h want 00500093", seen); end
   endtask

   task automatic test_load_collision();
      load_word(8'd5, 32'h0000_5555);
      read_en = 1'b1; addr = 32'd20;
      step();
      read_en   = 1'b0;
      load_en   = 1'b1;
      load_addr = 8'd5;
      load_data = 32'hAAAA_0005;
      step();
      load_en = 1'b0;
      step();
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b want 1", valid1); end
      checks++; if (rdata1 !== 32'h0000_5555) begin errors++; $display("FAIL coll_old: got %h want 00005555", rdata1); end
      read_en = 1'b1; addr = 32'd20;
      step();
      read_en = 1'b0;
      step();
      step();
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL coll_valid2: got %b want 1", valid1); end
      checks++; if (rdata1 !== 32'hAAAA_0005) begin errors++; $display("FAIL coll_new: got %h want aaaa0005", rdata1); end
   endtask

   task automatic test_back_to_back();
      load_word(8'd0, 32'hA000_000A);
      load_word(8'd1, 32'hB000_000B);
      load_word(8'd2, 32'hC000_000C);
      read_en = 1'b1; addr = 32'h0;
      step();
      checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL b2b_first: got %b want 0", valid0); end
      addr = 32'h4;
      step();
      checks++; if (valid0 !== 1'b1 || rdata0 !== 32'hA000_000A) begin
         errors++; $display("FAIL b2b_a: got valid=%b rdata=%h want 1 a000000a", valid0, rdata0);
      end
      addr = 32'h8;
      step();
      checks++; if (valid0 !== 1'b1 || rdata0 !== 32'hB000_000B) begin
         errors++; $display("FAIL b2b_b: got valid=%b rdata=%h want 1 b000000b", valid0, rdata0);
      end
      read_en = 1'b0;
      step();
      checks++; if (valid0 !== 1'b1 || rdata0 !== 32'hC000_000C) begin
         errors++; $display("FAIL b2b_c: got valid=%b rdata=%h want 1 c000000c", valid0, rdata0);
      end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy0); end
      step();
      checks++; if (valid0 !== 1'b0 || rdata0 !== 32'hC000_000C) begin
         errors++; $display("FAIL b2b_end: got valid=%b rdata=%h want 0 c000000c", valid0, rdata0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      read_en   = 1'b0;
      addr      = 32'h0;
      load_en   = 1'b0;
      load_addr = 8'd0;
      load_data = 32'h0;
      test_reset();
      test_single_fetch();
      test_errors();
      test_wait_drop();
      test_reset_mid_wait();
      test_load_collision();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
